// File: rtl/parse_pkg.sv
// Shared parse-stage constants and types for the packet-buffer address manager.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package parse_pkg;

    localparam int BUF_ADDR_W      = 8;
    localparam int BUF_NUM         = 256;
    localparam int BUF_FULL_THRESH = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/buf_rr_arb2.sv
// Two-input round-robin arbiter; index 0 = cut path, index 1 = nocut path.
// Latency: grant is combinational from req/en; the priority flag updates at the next edge.
// Backpressure: en low blocks all grants, and a losing requester simply waits.
module buf_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Set when the nocut path should win the next tie; cleared after reset.
    logic prio_nocut;

    // Pick one requester: a lone request wins, and a tie goes to whoever lost last.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && req[1]) begin
                gnt = prio_nocut ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // Hand priority to the side that did not win on every granted cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_nocut <= 1'b0;
        end else if (|gnt) begin
            prio_nocut <= gnt[0];
        end
    end

endmodule

// File: rtl/parse_buf_addr_mgr.sv
// Free-list manager that hands packet-buffer addresses to the cut and nocut writers.
// Latency: grant and address are combinational; a freed address is allocatable one cycle later.
// Backpressure: buf_addr_full holds off the parser during init and when fewer than FULL_THRESH are free.
module parse_buf_addr_mgr
    import parse_pkg::*;
#(
    parameter int ADDR_W      = BUF_ADDR_W,
    parameter int NUM_BUF     = BUF_NUM,
    parameter int FULL_THRESH = BUF_FULL_THRESH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_req_cut,
    input  logic              alloc_req_nocut,
    output logic              alloc_gnt_cut,
    output logic              alloc_gnt_nocut,
    output logic [ADDR_W-1:0] alloc_addr,
    input  logic              free_valid,
    input  logic [ADDR_W-1:0] free_addr,
    output logic              buf_addr_full,
    output logic [ADDR_W:0]   free_cnt,
    output logic              err_bad_free
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BUF - 1);
    localparam logic [ADDR_W:0]   THRESH   = (ADDR_W + 1)'(FULL_THRESH);

    buf_state_e        state;
    logic [ADDR_W-1:0] mem [NUM_BUF];
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic [ADDR_W:0]   cnt;
    logic [NUM_BUF-1:0] alloc_map;

    logic              arb_en;
    logic [1:0]        gnt;
    logic              grant_any;
    logic [ADDR_W-1:0] head_addr;
    logic              map_hit;
    logic              good_free;
    logic              bad_free;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wdat;

    // Grants only make sense once the list is built and something is left in it.
    assign arb_en = (state == ST_RUN) && (cnt != '0);

    buf_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req   ({alloc_req_nocut, alloc_req_cut}),
        .gnt   (gnt)
    );

    assign alloc_gnt_cut   = gnt[0];
    assign alloc_gnt_nocut = gnt[1];
    assign grant_any       = |gnt;
    assign head_addr       = mem[head];
    assign alloc_addr      = grant_any ? head_addr : '0;

    // Ownership is judged against the pre-grant map, so freeing the address
    // being granted this same cycle is treated as a bad free.
    assign map_hit   = alloc_map[free_addr];
    assign good_free = (state == ST_RUN) && free_valid && map_hit;
    assign bad_free  = (state == ST_RUN) && free_valid && !map_hit;

    assign buf_addr_full = (state == ST_INIT) || (cnt < THRESH);
    assign free_cnt      = cnt;

    // Select the free-list write: identity fill during init, returned address during run.
    always_comb begin
        mem_we   = 1'b0;
        mem_wdat = '0;
        if (!reset) begin
            if (state == ST_INIT) begin
                mem_we   = 1'b1;
                mem_wdat = tail;
            end else if (good_free) begin
                mem_we   = 1'b1;
                mem_wdat = free_addr;
            end
        end
    end

    // Free-list storage; contents are rebuilt by init so no reset is needed.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[tail] <= mem_wdat;
        end
    end

    // Control FSM with pointers, occupancy, ownership map and bad-free pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_INIT;
            head         <= '0;
            tail         <= '0;
            cnt          <= '0;
            alloc_map    <= '0;
            err_bad_free <= 1'b0;
        end else begin
            err_bad_free <= 1'b0;
            case (state)
                ST_INIT: begin
                    tail <= tail + 1'b1;
                    cnt  <= cnt + 1'b1;
                    if (tail == LAST_IDX) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    err_bad_free <= bad_free;
                    if (grant_any) begin
                        head                 <= head + 1'b1;
                        alloc_map[head_addr] <= 1'b1;
                    end
                    if (good_free) begin
                        tail                 <= tail + 1'b1;
                        alloc_map[free_addr] <= 1'b0;
                    end
                    case ({good_free, grant_any})
                        2'b10:   cnt <= cnt + 1'b1;
                        2'b01:   cnt <= cnt - 1'b1;
                        default: cnt <= cnt;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: doc/parse_buf_addr_mgr.md
# parse_buf_addr_mgr

Packet-buffer address manager for the IPv6/LISP parse stage. It owns a free list of NUM_BUF packet-buffer addresses and hands them out to two requesters, the cut-path and nocut-path writers in the dispatcher, using round-robin arbitration. It takes addresses back when downstream releases them. It drives `buf_addr_full` back to the header parser so the parser stops accepting packets before buffers run out.

## Interface
Parameters:
- `ADDR_W`, 8, buffer address width
- `NUM_BUF`, 256, number of buffers; must equal 2**ADDR_W
- `FULL_THRESH`, 4, `buf_addr_full` asserts while free count < FULL_THRESH

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `alloc_req_cut`  in  1  cut path requests one address (valid, level)
- `alloc_req_nocut`  in  1  nocut path requests one address
- `alloc_gnt_cut`  out  1  grant to cut path (ready); one address consumed per cycle high
- `alloc_gnt_nocut`  out  1  grant to nocut path
- `alloc_addr`  out  ADDR_W  granted address; valid when either grant is high, else 0
- `free_valid`  in  1  release strobe
- `free_addr`  in  ADDR_W  address being released
- `buf_addr_full`  out  1  back-pressure to the parser
- `free_cnt`  out  ADDR_W+1  current free-list occupancy
- `err_bad_free`  out  1  one-cycle pulse on release of an address not currently allocated

## Operation
- **Storage.** The free list is a circular FIFO: NUM_BUF x ADDR_W register array, `head`/`tail` pointers of ADDR_W bits with natural wrap, and a `cnt` register of ADDR_W+1 bits.
- **Ownership tracking.** A NUM_BUF-bit `alloc_map` tracks ownership.
- **State INIT (entered on reset).**
  - Writes address i to entry i at tail, one per cycle, i = 0..NUM_BUF-1.
  - `cnt` increments by 1 each cycle.
  - Grants are forced 0, `buf_addr_full`=1, and `free_valid` is ignored.
  - After the write of NUM_BUF-1 the block moves to RUN.
- **State RUN: allocation.**
  - Eligible when `cnt` != 0.
  - If only one request is high, that requester is granted.
  - If both are high, the requester that did not win last time is granted. After reset, priority is cut first.
  - Grant is combinational from the requests and state, in the same cycle.
  - `alloc_addr` = mem[head].
  - On a grant: head+1, set `alloc_map[alloc_addr]`, update the last-winner flag.
  - A requester holding its request high receives one address per granted cycle.
- **State RUN: release.**
  - If `free_valid` is high and `alloc_map[free_addr]`=1: write mem[tail], tail+1, clear the map bit.
  - If the map bit is 0: the write is dropped and `err_bad_free` pulses the next cycle.
- **Counter.** `cnt` next = `cnt` + (good free) − (grant).
  - Simultaneous grant and good free leaves `cnt` unchanged.
  - Freeing the address granted in the same cycle counts as a bad free, because the map is checked with the pre-grant value.
- **Back-pressure.** `buf_addr_full` = (state==INIT) | (`cnt` < FULL_THRESH). This is combinational from registers.
- **Reset mid-operation.** Returns to INIT, clears `alloc_map`, `cnt`, pointers and the winner flag. All outstanding allocations are forgotten.

## Timing
- Reset values: `alloc_gnt_*`=0, `alloc_addr`=0, `buf_addr_full`=1, `free_cnt`=0, `err_bad_free`=0.
- INIT lasts exactly NUM_BUF cycles after reset deasserts. `free_cnt`=NUM_BUF and `buf_addr_full`=0 at cycle NUM_BUF, and grants are possible from that cycle.
- Grant latency is 0 cycles. The address and map update take effect at the next edge.
- A freed address becomes visible in `free_cnt` and is allocatable from the next cycle.
- When the list is empty (`cnt`=0), no grant is given and requests wait.
- A full list with a good free cannot occur, because the map guarantees it.

## Structure
- Shared package `parse_pkg`: `BUF_ADDR_W`, `BUF_NUM`, `BUF_FULL_THRESH`, and the state enum {INIT, RUN}.
- One sub-module, `buf_rr_arb2`: 2-input round-robin arbiter with enable, last-winner register, and a one-hot grant out.
- The free-list FIFO, map and counter stay inline.

## Test plan
- **Init.** Release reset → grants 0 and `buf_addr_full`=1 for 256 cycles; at cycle 256 `free_cnt`=256, `buf_addr_full`=0.
- **Single requester.** `alloc_req_cut` held 3 cycles → grants on each, addresses 0,1,2; `free_cnt`=253.
- **Contention.** Both requests held 4 cycles → grant order cut, nocut, cut, nocut with addresses 0,1,2,3.
- **Exhaustion.** Allocate 253 → `buf_addr_full` rises when `free_cnt`=3. Allocate 3 more → `free_cnt`=0 and further requests get no grant. Free address 7 → next cycle grant with `alloc_addr`=7.
- **Simultaneous alloc and good free.** `free_cnt` unchanged; the freed address reappears only after the pointer wraps.
- **Bad free.** Free address 9 twice → second free gives `err_bad_free` pulse, `free_cnt` increments only once. Reset mid-run → INIT repeats and addresses restart at 0.
